fmes_bcd_out: RTL and testbench
===============================

Name: fmes_bcd_out

Overview:
- Result formatter that sits downstream of the reciprocal frequency meter's divider.
- Captures the integer part Q and binary fraction F when the divider raises ok_div.
- Converts them sequentially to packed BCD: double-dabble for the integer part, repeated ×10 for the fraction.
- Presents double-buffered digits plus a one-cycle ok_bcd strobe to the display/readout stage.

Parameters:
- Q_W, 20, width of integer result input q
- F_W, 10, width of fractional input f (value = f / 2^F_W)
- N_INT, 6, number of integer BCD digits
- N_FRAC, 3, number of fractional BCD digits

Ports:
- clk  in  1  system clock (same clock as the divider)
- rst_n  in  1  synchronous reset, active low
- ok_div  in  1  divider result-valid level; a rising edge starts conversion
- q  in  Q_W  integer part of the measured frequency
- f  in  F_W  fractional part of the measured frequency
- bcd_int  out  4*N_INT  integer digits, MS digit in the top nibble
- bcd_frac  out  4*N_FRAC  fractional digits, first digit after the point in the top nibble
- ovf  out  1  integer part exceeded N_INT digits
- busy  out  1  conversion in progress
- ok_bcd  out  1  one-cycle strobe: new bcd_int/bcd_frac/ovf valid

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-low (rst_n).
- Reset values: bcd_int=0, bcd_frac=0, ovf=0, busy=0, ok_bcd=0, state=IDLE.
- Edge-detect register ok_div_d resets to 1, so an ok_div already high at reset release does not trigger.
- Start condition: ok_div=1 and ok_div_d=0, sampled at edge k, state IDLE.
  - At edge k: q and f are captured into working registers, the BCD accumulator is cleared, state moves to INT, busy=1.
- INT: Q_W cycles (edges k+1..k+Q_W).
  - Each cycle: add 3 to every accumulator digit >=5, then shift left one bit, taking in the MSB of the q shadow.
  - Accumulator is N_INT+1 digits wide; the extra top digit exists for overflow detection.
- FRAC: N_FRAC cycles (edges k+Q_W+1..k+Q_W+N_FRAC).
  - Each cycle: p = frac*10 (F_W+4 bits). Next digit = p[F_W+3:F_W]; frac = p[F_W-1:0].
  - Digits fill from the MS nibble. Truncation, no rounding.
- DONE at edge k+Q_W+N_FRAC+1:
  - Output registers load.
  - ok_bcd=1 for exactly that cycle; busy=0; state returns to IDLE.
  - Latency with defaults: 24 clocks from the start edge to the ok_bcd edge.
- Overflow: if the extra top digit is nonzero, ovf=1 and bcd_int is set to all 9s (0x999999 with defaults). bcd_frac is still converted normally.
- Outputs hold their previous values for the whole conversion; they change only at DONE.
- A rising edge of ok_div while busy is ignored, with no queuing. ok_div_d still tracks ok_div every cycle.
- A start edge in the same cycle as DONE is ignored, because state is not IDLE at that edge.
- rst_n low in any state: returns to IDLE next edge, outputs go to reset values, and the partial conversion is discarded.
- q=0: bcd_int=0. f=0: bcd_frac=0.

Optional Feature:
- Macro: FMES_BCD_BLANK_EN.
- Defined: at DONE, leading-zero integer digits above the units digit are replaced by 4'hF (blank code for the display decoder). The units digit is never blanked. When ovf=1, no blanking is applied.
- Undefined: leading zeros are output as 4'h0.
- Timing and all other outputs are identical in both builds.

Test Plan:
- q=12345, f=512, ok_div 0->1 -> after 24 clocks ok_bcd pulses once; bcd_int=0x012345, bcd_frac=0x500, ovf=0 (with BLANK_EN: bcd_int=0xF12345).
- q=999999, f=1023 -> bcd_int=0x999999, bcd_frac=0x999 (0.99902 truncated), ovf=0.
- q=1048575, f=0 -> ovf=1, bcd_int=0x999999, bcd_frac=0x000.
- Result A converted; second ok_div rising edge at clock 10 of conversion B -> ignored, single ok_bcd; bcd_int holds A until B's DONE.
- rst_n pulsed low at clock 12 of a conversion -> next cycle all outputs 0, busy=0, no ok_bcd. ok_div held high through reset release -> no conversion starts.
- q=0, f=0 -> bcd_int=0x000000 (BLANK_EN: 0xFFFFF0), bcd_frac=0x000, ok_bcd after 24 clocks.

Source files
------------

// File: rtl/fmes_bcd_out.sv
// Sequential binary-to-BCD formatter for the frequency meter result (Q integer, F fraction).
// Optional FMES_BCD_BLANK_EN: blank leading integer zeros with 4'hF.
module fmes_bcd_out #(
    parameter int unsigned Q_W    = 20,
    parameter int unsigned F_W    = 10,
    parameter int unsigned N_INT  = 6,
    parameter int unsigned N_FRAC = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ok_div,
    input  logic [Q_W-1:0]        q,
    input  logic [F_W-1:0]        f,
    output logic [4*N_INT-1:0]    bcd_int,
    output logic [4*N_FRAC-1:0]   bcd_frac,
    output logic                  ovf,
    output logic                  busy,
    output logic                  ok_bcd
);

    localparam int unsigned AccW  = 4 * (N_INT + 1);
    localparam int unsigned FdigW = 4 * N_FRAC;
    localparam int unsigned CntW  = $clog2(Q_W + N_FRAC + 1);
    localparam int unsigned ProdW = F_W + 4;

    typedef enum logic [1:0] {StIdle, StInt, StFrac, StDone} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [Q_W-1:0]     q_sh_q, q_sh_d;
    logic [F_W-1:0]     frac_q, frac_d;
    logic [AccW-1:0]    acc_q, acc_d, acc_adj;
    logic [FdigW-1:0]   fdig_q, fdig_d;
    logic               ok_div_q;
    logic               start;
    logic [ProdW-1:0]   prod;
    logic [4*N_INT-1:0] int_res;
    logic               ovf_res;
    logic [4*N_INT-1:0] bcd_int_q;
    logic [FdigW-1:0]   bcd_frac_q;
    logic               ovf_q, ok_bcd_q;

    assign start = ok_div & ~ok_div_q;
    assign prod  = ProdW'(frac_q) * ProdW'(10);

    // Double-dabble correction: digits >= 5 get +3 before the shift.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < int'(N_INT + 1); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_sh_d  = q_sh_q;
        frac_d  = frac_q;
        acc_d   = acc_q;
        fdig_d  = fdig_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    q_sh_d  = q;
                    frac_d  = f;
                    acc_d   = '0;
                    fdig_d  = '0;
                    cnt_d   = '0;
                    state_d = StInt;
                end
            end
            StInt: begin
                acc_d  = {acc_adj[AccW-2:0], q_sh_q[Q_W-1]};
                q_sh_d = q_sh_q << 1;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(Q_W - 1)) begin
                    cnt_d   = '0;
                    state_d = StFrac;
                end
            end
            StFrac: begin
                fdig_d = (fdig_q << 4) | FdigW'(prod[F_W+3:F_W]);
                frac_d = prod[F_W-1:0];
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(N_FRAC - 1)) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ovf_res = |acc_q[AccW-1 -: 4];
        int_res = ovf_res ? {N_INT{4'h9}} : acc_q[4*N_INT-1:0];
`ifdef FMES_BCD_BLANK_EN
        begin
            logic lead;
            lead = ~ovf_res;
            // Units digit (i = 0) is never blanked.
            for (int i = int'(N_INT) - 1; i >= 1; i--) begin
                if (lead && (int_res[4*i +: 4] == 4'h0)) begin
                    int_res[4*i +: 4] = 4'hF;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            q_sh_q     <= '0;
            frac_q     <= '0;
            acc_q      <= '0;
            fdig_q     <= '0;
            ok_div_q   <= 1'b1;  // level already high at reset release must not start
            bcd_int_q  <= '0;
            bcd_frac_q <= '0;
            ovf_q      <= 1'b0;
            ok_bcd_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_sh_q   <= q_sh_d;
            frac_q   <= frac_d;
            acc_q    <= acc_d;
            fdig_q   <= fdig_d;
            ok_div_q <= ok_div;
            ok_bcd_q <= (state_q == StDone);
            if (state_q == StDone) begin
                bcd_int_q  <= int_res;
                bcd_frac_q <= fdig_q;
                ovf_q      <= ovf_res;
            end
        end
    end

    assign bcd_int  = bcd_int_q;
    assign bcd_frac = bcd_frac_q;
    assign ovf      = ovf_q;
    assign ok_bcd   = ok_bcd_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_fmes_bcd_out.sv
// Scoreboard bench for fmes_bcd_out: expected digits are queued at each start and checked at ok_bcd.
module tb_fmes_bcd_out;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ok_div;
    logic [19:0] q;
    logic [9:0]  f;
    logic [23:0] bcd_int;
    logic [11:0] bcd_frac;
    logic        ovf, busy, ok_bcd;

    fmes_bcd_out dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ok_div   (ok_div),
        .q        (q),
        .f        (f),
        .bcd_int  (bcd_int),
        .bcd_frac (bcd_frac),
        .ovf      (ovf),
        .busy     (busy),
        .ok_bcd   (ok_bcd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] bi;
        logic [11:0] bf;
        logic        ov;
    } exp_t;

    exp_t sb_q[$];
    exp_t last;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t model(int unsigned qv, int unsigned fv);
        exp_t        e;
        int unsigned r;
        int unsigned fr;
        logic        lead;
        e.ov = (qv > 999999);
        if (e.ov) begin
            e.bi = 24'h999999;
        end else begin
            r = qv;
            for (int i = 0; i < 6; i++) begin
                e.bi[4*i +: 4] = 4'(r % 10);
                r = r / 10;
            end
`ifdef FMES_BCD_BLANK_EN
            lead = 1'b1;
            for (int i = 5; i >= 1; i--) begin
                if (lead && e.bi[4*i +: 4] == 4'h0) e.bi[4*i +: 4] = 4'hF;
                else lead = 1'b0;
            end
`endif
        end
        fr = fv;
        for (int i = 2; i >= 0; i--) begin
            fr = fr * 10;
            e.bf[4*i +: 4] = 4'(fr >> 10);
            fr = fr & 32'd1023;
        end
        return e;
    endfunction

    // Raises ok_div (caller guarantees it was low last cycle) and queues the expectation.
    task automatic drive_start(input int unsigned qv, input int unsigned fv);
        logic [31:0] qq, ff;
        qq = qv;
        ff = fv;
        q = qq[19:0];
        f = ff[9:0];
        ok_div = 1'b1;
        sb_q.push_back(model(qv, fv));
    endtask

    // Waits for ok_bcd; cycle 1 is the start edge. Optionally replays a rising edge at rise_at.
    task automatic wait_done(input int rise_at, output int lat, output bit busy_start,
                             output bit held);
        lat = -1;
        held = 1'b1;
        busy_start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                busy_start = busy;
                ok_div = 1'b0;
            end
            if (ok_bcd) begin
                lat = cyc;
                break;
            end
            if (bcd_int !== last.bi || bcd_frac !== last.bf || ovf !== last.ov) held = 1'b0;
            if (cyc == rise_at) ok_div = 1'b1;
            if (rise_at > 0 && cyc == rise_at + 2) ok_div = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ok_div = 1'b0;
        q = '0;
        f = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bcd_int !== 24'h0) begin
            n_bad++; $display("FAIL reset_bcd_int: got %h want 000000", bcd_int);
        end
        n_cmp++;
        if (bcd_frac !== 12'h0) begin
            n_bad++; $display("FAIL reset_bcd_frac: got %h want 000", bcd_frac);
        end
        n_cmp++;
        if ({ovf, busy, ok_bcd} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: ovf/busy/ok_bcd got %b want 000",
                              {ovf, busy, ok_bcd});
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        last = '0;
    endtask

    task automatic test_convert;
        int unsigned qs[6];
        int unsigned fs[6];
        int   lat;
        bit   bs, held;
        exp_t e;
        qs = '{12345, 999999, 1048575, 0, $urandom_range(0, 1048575), $urandom_range(0, 999999)};
        fs = '{512, 1023, 0, 0, $urandom_range(0, 1023), $urandom_range(0, 1023)};
        foreach (qs[i]) begin
            drive_start(qs[i], fs[i]);
            wait_done(0, lat, bs, held);
            n_cmp++;
            if (lat != 25) begin
                n_bad++; $display("FAIL conv%0d_latency: got %0d want 25 (start edge = 1)", i, lat);
            end
            n_cmp++;
            if (!bs) begin
                n_bad++; $display("FAIL conv%0d_busy_start: got 0 want 1", i);
            end
            n_cmp++;
            if (!held) begin
                n_bad++; $display("FAIL conv%0d_hold: outputs changed before ok_bcd, want held", i);
            end
            if (sb_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL conv%0d_scoreboard: got empty queue want 1 entry", i);
            end else begin
                e = sb_q.pop_front();
                n_cmp++;
                if ({bcd_int, bcd_frac, ovf} !== {e.bi, e.bf, e.ov}) begin
                    n_bad++;
                    $display("FAIL conv%0d_result q=%0d f=%0d: got int=%h frac=%h ovf=%b want int=%h frac=%h ovf=%b",
                             i, qs[i], fs[i], bcd_int, bcd_frac, ovf, e.bi, e.bf, e.ov);
                end
                last = e;
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                n_bad++; $display("FAIL conv%0d_busy_done: got %b want 0", i, busy);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (ok_bcd !== 1'b0) begin
                n_bad++; $display("FAIL conv%0d_strobe_width: ok_bcd got %b want 0", i, ok_bcd);
            end
        end
    endtask

    // Rising edges during a conversion (mid-way and at DONE) are dropped, not queued.
    task automatic test_back_to_back;
        int unsigned qs[3] = '{654321, 77, 40000};
        int unsigned fs[3] = '{100, 900, 1};
        int          rs[3] = '{0, 10, 24};
        int   lat, extra;
        bit   bs, held;
        exp_t e;
        foreach (qs[i]) begin
            drive_start(qs[i], fs[i]);
            wait_done(rs[i], lat, bs, held);
            ok_div = 1'b0;
            n_cmp++;
            if (lat != 25 || !held) begin
                n_bad++; $display("FAIL b2b%0d_timing: got lat=%0d held=%b want lat=25 held=1",
                                  i, lat, held);
            end
            e = sb_q.pop_front();
            n_cmp++;
            if ({bcd_int, bcd_frac, ovf} !== {e.bi, e.bf, e.ov}) begin
                n_bad++; $display("FAIL b2b%0d_result: got int=%h frac=%h ovf=%b want int=%h frac=%h ovf=%b",
                                  i, bcd_int, bcd_frac, ovf, e.bi, e.bf, e.ov);
            end
            last = e;
            extra = 0;
            for (int c = 0; c < 30; c++) begin
                @(posedge clk); #1;
                if (ok_bcd || busy) extra++;
            end
            n_cmp++;
            if (extra != 0) begin
                n_bad++; $display("FAIL b2b%0d_no_requeue: got %0d busy/ok cycles want 0", i, extra);
            end
        end
    endtask

    task automatic test_reset_mid;
        int   lat, extra;
        bit   bs, held;
        exp_t e;
        drive_start(123456, 700);
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) ok_div = 1'b0;
        end
        rst_n = 1'b0;
        ok_div = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({bcd_int, bcd_frac, ovf, busy, ok_bcd} !== 39'h0) begin
            n_bad++; $display("FAIL rst_mid_outputs: got int=%h frac=%h ovf=%b busy=%b ok=%b want all 0",
                              bcd_int, bcd_frac, ovf, busy, ok_bcd);
        end
        sb_q.delete();
        last = '0;
        rst_n = 1'b1;
        extra = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (ok_bcd || busy) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++; $display("FAIL rst_high_ok_div: got %0d busy/ok cycles want 0", extra);
        end
        ok_div = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drive_start(321, 256);
        wait_done(0, lat, bs, held);
        e = sb_q.pop_front();
        n_cmp++;
        if (lat != 25 || {bcd_int, bcd_frac, ovf} !== {e.bi, e.bf, e.ov}) begin
            n_bad++; $display("FAIL rst_recover: got lat=%0d int=%h frac=%h want lat=25 int=%h frac=%h",
                              lat, bcd_int, bcd_frac, e.bi, e.bf);
        end
        last = e;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_convert();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
